// File: rtl/alu_issue_decode.sv
// Single-stage MIPS ALU issue/decode: decodes the offered instruction, selects
// operands from the register file and holds one registered op under valid/ready.
module alu_issue_decode (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] out_pc,
    output logic        illegal
);
    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND  = 12'h080;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_XOR  = 12'h010;
    localparam logic [11:0] OP_SLL  = 12'h008;
    localparam logic [11:0] OP_SRL  = 12'h004;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    logic [11:0] dec_ctrl;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic [4:0]  dec_waddr;
    logic        dec_legal;

    logic        capture;

    logic        out_valid_q,   out_valid_d;
    logic [11:0] alu_control_q, alu_control_d;
    logic [31:0] alu_src1_q,    alu_src1_d;
    logic [31:0] alu_src2_q,    alu_src2_d;
    logic        rf_wen_q,      rf_wen_d;
    logic [4:0]  rf_waddr_q,    rf_waddr_d;
    logic [31:0] out_pc_q,      out_pc_d;
    logic        illegal_q,     illegal_d;

    assign opcode    = in_inst[31:26];
    assign funct     = in_inst[5:0];
    assign imm_sext  = {{16{in_inst[15]}}, in_inst[15:0]};
    assign imm_zext  = {16'b0, in_inst[15:0]};
    assign rf_raddr1 = in_inst[25:21];
    assign rf_raddr2 = in_inst[20:16];

    always_comb begin
        dec_ctrl  = 12'b0;
        dec_src1  = rf_rdata1;
        dec_src2  = rf_rdata2;
        dec_waddr = in_inst[15:11];
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100000, 6'b100001: dec_ctrl = OP_ADD;
                6'b100011, 6'b100010: dec_ctrl = OP_SUB;
                6'b101010:            dec_ctrl = OP_SLT;
                6'b101011:            dec_ctrl = OP_SLTU;
                6'b100100:            dec_ctrl = OP_AND;
                6'b100111:            dec_ctrl = OP_NOR;
                6'b100101:            dec_ctrl = OP_OR;
                6'b100110:            dec_ctrl = OP_XOR;
                6'b000000, 6'b000100: dec_ctrl = OP_SLL;
                6'b000010, 6'b000110: dec_ctrl = OP_SRL;
                6'b000011, 6'b000111: dec_ctrl = OP_SRA;
                default:              dec_ctrl = 12'b0;
            endcase
            // Immediate shifts take the shift amount from the shamt field.
            if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)
                dec_src1 = {27'b0, in_inst[10:6]};
        end else begin
            dec_waddr = in_inst[20:16];
            case (opcode)
                6'b001000, 6'b001001: begin dec_ctrl = OP_ADD;  dec_src2 = imm_sext; end
                6'b001010:            begin dec_ctrl = OP_SLT;  dec_src2 = imm_sext; end
                6'b001011:            begin dec_ctrl = OP_SLTU; dec_src2 = imm_sext; end
                6'b001100:            begin dec_ctrl = OP_AND;  dec_src2 = imm_zext; end
                6'b001101:            begin dec_ctrl = OP_OR;   dec_src2 = imm_zext; end
                6'b001110:            begin dec_ctrl = OP_XOR;  dec_src2 = imm_zext; end
                6'b001111:            begin dec_ctrl = OP_LUI;  dec_src2 = imm_zext; end
                default:              dec_ctrl = 12'b0;
            endcase
        end
        dec_legal = |dec_ctrl;
        if (!dec_legal) begin
            dec_src1  = 32'b0;
            dec_src2  = 32'b0;
            dec_waddr = 5'b0;
        end
    end

    assign in_ready = ~flush & (~out_valid_q | out_ready);
    assign capture  = in_valid & in_ready;

    always_comb begin
        alu_control_d = alu_control_q;
        alu_src1_d    = alu_src1_q;
        alu_src2_d    = alu_src2_q;
        rf_wen_d      = rf_wen_q;
        rf_waddr_d    = rf_waddr_q;
        out_pc_d      = out_pc_q;
        illegal_d     = illegal_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (capture)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;
        if (capture) begin
            alu_control_d = dec_ctrl;
            alu_src1_d    = dec_src1;
            alu_src2_d    = dec_src2;
            rf_waddr_d    = dec_waddr;
            rf_wen_d      = dec_legal & (dec_waddr != 5'd0);
            out_pc_d      = in_pc;
            illegal_d     = ~dec_legal;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q   <= 1'b0;
            alu_control_q <= 12'b0;
            alu_src1_q    <= 32'b0;
            alu_src2_q    <= 32'b0;
            rf_wen_q      <= 1'b0;
            rf_waddr_q    <= 5'b0;
            out_pc_q      <= 32'b0;
            illegal_q     <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            alu_control_q <= alu_control_d;
            alu_src1_q    <= alu_src1_d;
            alu_src2_q    <= alu_src2_d;
            rf_wen_q      <= rf_wen_d;
            rf_waddr_q    <= rf_waddr_d;
            out_pc_q      <= out_pc_d;
            illegal_q     <= illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_control = alu_control_q;
    assign alu_src1    = alu_src1_q;
    assign alu_src2    = alu_src2_q;
    assign rf_wen      = rf_wen_q;
    assign rf_waddr    = rf_waddr_q;
    assign out_pc      = out_pc_q;
    assign illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue_decode.sv
// Bench for alu_issue_decode: directed decode vectors, handshake scenarios and a
// randomized run scored against a queue-based transaction model.
module tb_alu_issue_decode;
    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] alu_control;
    logic [31:0] alu_src1, alu_src2;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] out_pc;
    logic        illegal;

    logic [31:0] regs [32];
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] s1, s2, pc;
        logic [4:0]  wa;
        logic        wen, ill;
    } op_t;

    typedef struct {
        logic [31:0] inst, r1v, r2v;
        logic [11:0] ctrl;
        logic [31:0] s1, s2;
        logic [4:0]  wa;
        logic        wen, ill;
    } vec_t;

    op_t model_q[$];

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always #5 clk = ~clk;

    alu_issue_decode dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .out_pc(out_pc), .illegal(illegal)
    );

    // Mnemonic index 0..11 = add..lui; control word is a one-hot from the MSB.
    function automatic op_t ref_op(input logic [31:0] inst, input logic [31:0] pc);
        op_t o;
        int  idx = -1;
        logic [31:0] r1 = regs[inst[25:21]];
        logic [31:0] r2 = regs[inst[20:16]];
        logic [31:0] sx = {{16{inst[15]}}, inst[15:0]};
        logic [31:0] zx = {16'h0, inst[15:0]};
        o.pc = pc;
        if (inst[31:26] == 6'd0) begin
            case (inst[5:0])
                6'd32, 6'd33: idx = 0;
                6'd34, 6'd35: idx = 1;
                6'd42: idx = 2;
                6'd43: idx = 3;
                6'd36: idx = 4;
                6'd39: idx = 5;
                6'd37: idx = 6;
                6'd38: idx = 7;
                6'd0, 6'd4: idx = 8;
                6'd2, 6'd6: idx = 9;
                6'd3, 6'd7: idx = 10;
                default: idx = -1;
            endcase
            o.s1 = (inst[5:0] == 6'd0 || inst[5:0] == 6'd2 || inst[5:0] == 6'd3)
                   ? {27'd0, inst[10:6]} : r1;
            o.s2 = r2;
            o.wa = inst[15:11];
        end else begin
            o.s1 = r1;
            o.wa = inst[20:16];
            o.s2 = sx;
            case (inst[31:26])
                6'd8, 6'd9: idx = 0;
                6'd10: idx = 2;
                6'd11: idx = 3;
                6'd12: begin idx = 4;  o.s2 = zx; end
                6'd13: begin idx = 6;  o.s2 = zx; end
                6'd14: begin idx = 7;  o.s2 = zx; end
                6'd15: begin idx = 11; o.s2 = zx; end
                default: idx = -1;
            endcase
        end
        if (idx < 0) begin
            o.ctrl = 12'h0; o.s1 = 32'h0; o.s2 = 32'h0; o.wa = 5'd0;
            o.wen = 1'b0; o.ill = 1'b1;
        end else begin
            o.ctrl = 12'h800 >> idx;
            o.wen  = (o.wa != 5'd0);
            o.ill  = 1'b0;
        end
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        int fl[16] = '{32, 33, 34, 35, 42, 43, 36, 39, 37, 38, 0, 4, 2, 6, 3, 7};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        if (k <= 3) begin
            w[31:26] = 6'd0;
            w[5:0]   = 6'(fl[$urandom_range(0, 15)]);
        end else if (k <= 7) begin
            w[31:26] = 6'(8 + $urandom_range(0, 7));
        end else if (k == 9) begin
            w[31:26] = 6'd0;
            w[5:0]   = 6'd1;
        end
        return w;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_inst = 32'h2528FFFF;
        in_pc = 32'h100; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, rf_wen, illegal} !== 3'b000 || alu_control !== 12'h0 ||
            alu_src1 !== 32'h0 || alu_src2 !== 32'h0 || rf_waddr !== 5'h0 || out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b wen=%b ill=%b ctrl=%h s1=%h s2=%h wa=%h pc=%h, want all zero",
                     out_valid, rf_wen, illegal, alu_control, alu_src1, alu_src2, rf_waddr, out_pc);
        end
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
        $display("reset: checked idle state and in_ready");
    endtask

    task automatic test_vectors();
        vec_t vt[9] = '{
            '{32'h2528FFFF, 32'd5,      32'h77,       12'h800, 32'd5,    32'hFFFFFFFF, 5'd8, 1'b1, 1'b0},
            '{32'h00094100, 32'hAAAA,   32'hF,        12'h008, 32'd4,    32'hF,        5'd8, 1'b1, 1'b0},
            '{32'h3C081234, 32'h11,     32'h22,       12'h001, 32'h11,   32'h1234,     5'd8, 1'b1, 1'b0},
            '{32'h3128FFFF, 32'h33,     32'h44,       12'h080, 32'h33,   32'hFFFF,     5'd8, 1'b1, 1'b0},
            '{32'hFC000000, 32'h9,      32'h9,        12'h000, 32'h0,    32'h0,        5'd0, 1'b0, 1'b1},
            '{32'h00000000, 32'h5,      32'h6,        12'h008, 32'h0,    32'h6,        5'd0, 1'b0, 1'b0},
            '{32'h00221822, 32'd10,     32'd3,        12'h400, 32'd10,   32'd3,        5'd3, 1'b1, 1'b0},
            '{32'h2885FFFE, 32'h123,    32'h456,      12'h200, 32'h123,  32'hFFFFFFFE, 5'd5, 1'b1, 1'b0},
            '{32'h00831007, 32'h1F,     32'h80000000, 12'h002, 32'h1F,   32'h80000000, 5'd2, 1'b1, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            vec_t v = vt[i];
            logic [31:0] pc = 32'h400 + 32'(i * 4);
            regs[v.inst[25:21]] = v.r1v;
            regs[v.inst[20:16]] = v.r2v;
            drive(1'b1, v.inst, pc, 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (rf_raddr1 !== v.inst[25:21] || rf_raddr2 !== v.inst[20:16]) begin
                n_fail++;
                $display("FAIL raddr[%0d]: got %0d/%0d want %0d/%0d", i, rf_raddr1, rf_raddr2,
                         v.inst[25:21], v.inst[20:16]);
            end
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || alu_control !== v.ctrl || alu_src1 !== v.s1 ||
                alu_src2 !== v.s2 || rf_wen !== v.wen || illegal !== v.ill || out_pc !== pc ||
                (!v.ill && rf_waddr !== v.wa)) begin
                n_fail++;
                $display("FAIL vector %h: got v=%b ctrl=%h s1=%h s2=%h wa=%0d wen=%b ill=%b pc=%h, want v=1 ctrl=%h s1=%h s2=%h wa=%0d wen=%b ill=%b pc=%h",
                         v.inst, out_valid, alu_control, alu_src1, alu_src2, rf_waddr, rf_wen,
                         illegal, out_pc, v.ctrl, v.s1, v.s2, v.wa, v.wen, v.ill, pc);
            end
            $display("vector %h: ctrl=%h s1=%h s2=%h", v.inst, alu_control, alu_src1, alu_src2);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ia = 32'h00221822, ib = 32'h3C081234;
        drive(1'b1, ia, 32'hA000, 1'b0, 1'b0);
        drive(1'b1, ib, 32'hB000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) drive(1'b1, ib, 32'hB000, 1'b0, 1'b0);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 32'hA000 || alu_control !== 12'h400 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h ctrl=%h rdy=%b want v=1 pc=0000a000 ctrl=400 rdy=0",
                         c, out_valid, out_pc, alu_control, in_ready);
            end
        end
        drive(1'b1, ib, 32'hB000, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_pc !== 32'hA000) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b pc=%h want rdy=1 pc=0000a000", in_ready, out_pc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'hB000 || alu_control !== 12'h001) begin
            n_fail++;
            $display("FAIL second_op: got v=%b pc=%h ctrl=%h want v=1 pc=0000b000 ctrl=001",
                     out_valid, out_pc, alu_control);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got v=%b want 0 (duplicate op)", out_valid);
        end
        $display("back_to_back: two ops through 3-cycle stall");
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00221822, 32'hC000, 1'b0, 1'b0);
        drive(1'b1, 32'h3C081234, 32'hD000, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_setup: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b want 0", out_valid);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%b pc=%h want v=0", out_valid, out_pc);
        end
        $display("flush: held and offered op dropped");
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h2528FFFF, 32'hE000, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup: got v=%b want 1", out_valid);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || rf_wen !== 1'b0 || out_pc !== 32'h0 || alu_control !== 12'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b wen=%b pc=%h ctrl=%h want all 0",
                     out_valid, rf_wen, out_pc, alu_control);
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        $display("async_reset: held op dropped without an edge");
    endtask

    task automatic test_random();
        op_t e;
        logic exp_rdy;
        int  txn = 0;
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), rand_inst(), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            #1;
            exp_rdy = !flush && (model_q.size() == 0 || out_ready);
            n_cmp++;
            if (out_valid !== (model_q.size() != 0) || in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_hs[%0d]: got v=%b rdy=%b want v=%b rdy=%b",
                         c, out_valid, in_ready, (model_q.size() != 0), exp_rdy);
            end
            if (model_q.size() != 0) begin
                e = model_q[0];
                n_cmp++;
                if (alu_control !== e.ctrl || alu_src1 !== e.s1 || alu_src2 !== e.s2 ||
                    rf_wen !== e.wen || illegal !== e.ill || out_pc !== e.pc ||
                    (!e.ill && rf_waddr !== e.wa)) begin
                    n_fail++;
                    $display("FAIL rand_op[%0d]: got ctrl=%h s1=%h s2=%h wa=%0d wen=%b ill=%b pc=%h want ctrl=%h s1=%h s2=%h wa=%0d wen=%b ill=%b pc=%h",
                             c, alu_control, alu_src1, alu_src2, rf_waddr, rf_wen, illegal, out_pc,
                             e.ctrl, e.s1, e.s2, e.wa, e.wen, e.ill, e.pc);
                end
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (out_ready && model_q.size() != 0) begin
                    e = model_q.pop_front();
                    txn++;
                    $display("txn %0d: pc=%h ctrl=%h s1=%h s2=%h wa=%0d wen=%b ill=%b",
                             txn, e.pc, e.ctrl, e.s1, e.s2, e.wa, e.wen, e.ill);
                end
                if (in_valid && exp_rdy) model_q.push_back(ref_op(in_inst, in_pc));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_decode.md
ALU_ISSUE_DECODE -- requirements
Module: alu_issue_decode

Interface
REQ-001 Params: none; all widths fixed (32-bit datapath, 12-bit one-hot ALU control, 5-bit register addresses).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  discard the held op and the op offered this cycle.
REQ-005 in_valid  in  1  fetch side offers in_inst/in_pc.
REQ-006 in_ready  out  1  stage accepts this cycle.
REQ-007 in_inst  in  32  MIPS instruction word.
REQ-008 in_pc  in  32  instruction address.
REQ-009 rf_raddr1 / rf_raddr2  out  5 each  combinational = in_inst[25:21] / in_inst[20:16].
REQ-010 rf_rdata1 / rf_rdata2  in  32 each  register-file data, same cycle.
REQ-011 out_valid  out  1  registered op valid toward ALU stage.
REQ-012 out_ready  in  1  ALU stage consumes this cycle.
REQ-013 alu_control  out  12  one-hot, bit 11..0 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
REQ-014 alu_src1 / alu_src2  out  32 each  ALU operands.
REQ-015 rf_wen  out  1;  rf_waddr  out  5;  out_pc  out  32;  illegal  out  1.

Function
REQ-016 One pipeline register stage; all outputs except in_ready and rf_raddr* SHALL be registered.
REQ-017 in_ready SHALL = ~flush & (~out_valid | out_ready).
REQ-018 Capture when in_valid & in_ready; out_valid SHALL be 1 the next cycle (latency 1).
REQ-019 out_valid SHALL clear when out_ready & out_valid & no capture; otherwise hold; held payload SHALL be stable while out_valid & ~out_ready.
REQ-020 Simultaneous consume and capture SHALL replace the payload with out_valid staying 1 (full throughput, one op/cycle).
REQ-021 flush SHALL clear out_valid next cycle, with priority over capture and hold.
REQ-022 R-type (opcode 0), by funct: 100000/100001 add; 100011/100010 sub; 101010 slt; 101011 sltu; 100100 and; 100111 nor; 100101 or; 100110 xor; 000000/000100 sll; 000010/000110 srl; 000011/000111 sra.
REQ-023 R-type: rf_waddr = inst[15:11]; src2 = rf_rdata2; src1 = rf_rdata1, except immediate shifts (funct 000000/000010/000011), where src1 = {27'b0, inst[10:6]}.
REQ-024 I-type: 001000/001001 add, 001010 slt, 001011 sltu (imm sign-extended); 001100 and, 001101 or, 001110 xor (imm zero-extended); 001111 lui (src2 = {16'b0, imm}).
REQ-025 I-type: src1 = rf_rdata1; rf_waddr = inst[20:16].
REQ-026 Exactly one alu_control bit SHALL be set for every legal op.
REQ-027 Any other encoding: alu_control = 0, src1 = src2 = 0, rf_wen = 0, illegal = 1.
REQ-028 rf_wen SHALL = legal & (rf_waddr != 0); out_pc = captured in_pc.
REQ-029 Overflow of add/sub is not trapped; no exception path.

Reset
REQ-030 While resetn = 0: out_valid, rf_wen and illegal SHALL be 0; alu_control, alu_src1, alu_src2, rf_waddr and out_pc SHALL be 0.
REQ-031 in_ready SHALL be 1 on the first edge after reset deassertion (flush = 0).
REQ-032 Reset asserted mid-stall SHALL drop the held op immediately, without waiting for a clock edge.

Verification
REQ-033 0x2528FFFF (addiu $8,$9,-1), rf_rdata1 = 5 -> next cycle alu_control = 0x800, src1 = 5, src2 = 0xFFFFFFFF, rf_waddr = 8, rf_wen = 1.
REQ-034 0x00094100 (sll $8,$9,4), rf_rdata2 = 0x0000000F -> alu_control = 0x008, src1 = 0x4, src2 = 0xF.
REQ-035 0x3C081234 (lui) -> alu_control = 0x001, src2 = 0x00001234; 0x3128FFFF (andi) -> alu_control = 0x080, src2 = 0x0000FFFF.
REQ-036 Back-pressure: two ops back-to-back, out_ready = 0 for 3 cycles -> first op held stable, in_ready = 0, second op accepted on the cycle out_ready rises, no loss or duplication.
REQ-037 flush asserted with out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, offered op dropped.
REQ-038 0xFC000000 -> illegal = 1, alu_control = 0, rf_wen = 0; 0x00000000 (sll $0) -> legal, rf_wen = 0.
